// File: rtl/stage_if_pkg.sv
// Shared definitions for the turbo RV32 instruction-fetch stage.
// - state_t            : one-hot fetch FSM encodings
// - RESET_PC_DEFAULT   : default first fetch address after reset
// - NOP                : canonical RV32 no-op (addi x0,x0,0)
package stage_if_pkg;

  typedef enum logic [3:0] {
    S_INIT = 4'h1,
    S_IF   = 4'h2,
    S_IW   = 4'h4,
    S_DLV  = 4'h8
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/stage_if.sv
// Instruction-fetch stage: producer side of the IF->ID interface.
// Issues one fetch at a time to instruction memory, holds the returned word
// until ID consumes it, and redirects on branch feedback from later stages.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   PC, Inst_Req_Valid           fetch request address / valid to inst memory
//   Inst_Req_Ready               inst memory accepts the request
//   Instruction, Inst_Valid      fetch response word / valid
//   Inst_Ready                   stage accepts the response
//   Inst_O, PC_O, Done_O         instruction, its PC and valid flag to ID
//   Branch_Target                redirect address (low two bits ignored)
//   Feedback_Branch              redirect: squash in-flight fetch/delivery
//   Feedback_Mem_Acc             ID frozen: delivery not consumed this cycle
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  input  logic [31:0] Instruction,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  output logic [31:0] Inst_O,
  output logic [31:0] PC_O,
  output logic        Done_O,
  input  logic [31:0] Branch_Target,
  input  logic        Feedback_Branch,
  input  logic        Feedback_Mem_Acc
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_inst;
  logic [31:0] r_pc_o;
  logic        r_kill;
  logic        w_kill_nxt;
  logic        w_latch;
  logic [31:0] w_target;

  assign w_target = {Branch_Target[31:2], 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_latch     = 1'b0;
    unique case (r_state)
      S_INIT: w_state_nxt = S_IF;
      S_IF: begin
        if (Feedback_Branch) begin
          w_pc_nxt = w_target;
          // Request for the old PC is accepted this same edge: its response
          // is still owed and must be swallowed.
          if (Inst_Req_Ready) w_kill_nxt = 1'b1;
        end
        if (Inst_Req_Ready) w_state_nxt = S_IW;
      end
      S_IW: begin
        if (Feedback_Branch) w_pc_nxt = w_target;
        if (Inst_Valid) begin
          w_kill_nxt = 1'b0;
          if (r_kill || Feedback_Branch) begin
            w_state_nxt = S_IF;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = S_DLV;
          end
        end else if (Feedback_Branch) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_DLV: begin
        if (Feedback_Branch) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_IF;
        end else if (!Feedback_Mem_Acc) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_IF;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_kill_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_INIT;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_pc_o  <= '0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      if (w_latch) begin
        r_inst <= Instruction;
        r_pc_o <= r_pc;
      end
    end
  end

  assign PC             = r_pc;
  assign Inst_Req_Valid = (r_state == S_IF);
  assign Inst_Ready     = (r_state == S_IW);
  assign Done_O         = (r_state == S_DLV);
  assign Inst_O         = r_inst;
  assign PC_O           = r_pc_o;

endmodule
